// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and sequencer state encoding
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_SLL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_e;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file, two operand read ports, debug read port, one write port
module alu_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Entry 0 is never written, so it reads back as its reset value of zero.
   always_comb begin
      mem_d = mem_q;
      if (we && (waddr != '0)) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata1   = mem_q[raddr1];
   assign rdata2   = mem_q[raddr2];
   assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - registered command front end and write-back for an external 32-bit ALU
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_f,
   input  logic              alu_of,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zf_q,
   output logic              of_q
);

   state_e            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              zf_d, of_d;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rs1_data, rs2_data;

   alu_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (rf_we),
      .waddr    (rf_waddr),
      .wdata    (rf_wdata),
      .raddr1   (cmd_rs1),
      .raddr2   (cmd_rs2),
      .dbg_addr (dbg_addr),
      .rdata1   (rs1_data),
      .rdata2   (rs2_data),
      .dbg_data (dbg_data)
   );

   // Preload and write-back live in disjoint states, so the write port never sees both.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      result_d  = result_q;
      zf_d      = zf_q;
      of_d      = of_q;
      cmd_ready = 1'b0;
      done      = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = rd_q;
      rf_wdata  = result_q;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (ld_en) begin
               rf_we    = 1'b1;
               rf_waddr = ld_addr;
               rf_wdata = ld_data;
            end
            if (cmd_valid) begin
               op_d    = cmd_op;
               rd_d    = cmd_rd;
               alu_a_d = rs1_data;
               alu_b_d = rs2_data;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_f;
            zf_d     = (alu_f == '0);
            // OF is only meaningful for arithmetic; otherwise it may be X.
            of_d     = ((op_q == ALU_ADD) || (op_q == ALU_SUB)) ? alu_of : 1'b0;
            state_d  = WB;
         end
         WB: begin
            done    = 1'b1;
            rf_we   = (rd_q != '0);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         result_q <= '0;
         zf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         result_q <= result_d;
         zf_q     <= zf_d;
         of_q     <= of_d;
      end
   end

   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign alu_op = op_q;
   assign result = result_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench with a behavioural ALU on the ALU side
module tb_alu_cmd_sequencer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_rs1, cmd_rs2, cmd_rd;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;
   logic [DATA_W-1:0] alu_a, alu_b, alu_f;
   logic [2:0]        alu_op;
   logic              alu_of;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              zf_q, of_q;

   logic [1:0]        of_mode;
   logic [DATA_W-1:0] m_f;
   logic              m_of;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_f(alu_f), .alu_of(alu_of),
      .done(done), .result(result), .zf_q(zf_q), .of_q(of_q)
   );

   // Behavioural stand-in for the external ALU; of_mode forces OF to 1 or X.
   always_comb begin
      m_f  = '0;
      m_of = 1'b0;
      case (alu_op)
         3'b000: m_f = alu_a & alu_b;
         3'b001: m_f = alu_a | alu_b;
         3'b010: m_f = alu_a ^ alu_b;
         3'b011: m_f = ~(alu_a | alu_b);
         3'b100: begin
            m_f  = alu_a + alu_b;
            m_of = (alu_a[31] == alu_b[31]) && (m_f[31] != alu_a[31]);
         end
         3'b101: begin
            m_f  = alu_a - alu_b;
            m_of = (alu_a[31] != alu_b[31]) && (m_f[31] != alu_a[31]);
         end
         3'b110: m_f = {31'b0, ($signed(alu_a) < $signed(alu_b))};
         default: m_f = alu_b << alu_a[4:0];
      endcase
   end

   assign alu_f  = m_f;
   assign alu_of = (of_mode == 2'd1) ? 1'b1 : (of_mode == 2'd2) ? 1'bx : m_of;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ld(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   // Returns one tick after the accepting edge, i.e. in EXEC.
   task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
                        input logic [ADDR_W-1:0] d, input bit hold);
      int n;
      cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = s1; cmd_rs2 = s2; cmd_rd = d;
      n = 0;
      while (!cmd_ready && n < 10) begin
         step();
         n++;
      end
      if (!cmd_ready) begin
         tests++; fails++;
         $display("FAIL issue_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end
      step();
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
      tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_result: got %h want 0", result); end
      tests++; if ({zf_q, of_q} !== 2'b00) begin fails++; $display("FAIL rst_flags: got %b want 00", {zf_q, of_q}); end
      tests++; if (alu_op !== 3'b000) begin fails++; $display("FAIL rst_alu_op: got %b want 000", alu_op); end
      tests++; if ({alu_a, alu_b} !== 64'h0) begin fails++; $display("FAIL rst_operands: got %h want 0", {alu_a, alu_b}); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_add_overflow();
      do_ld(5'd1, 32'h7FFF_0000);
      do_ld(5'd2, 32'h7FFF_0000);
      issue(3'b100, 5'd1, 5'd2, 5'd3, 1'b0);
      dbg_addr = 5'd3;
      tests++; if (alu_a !== 32'h7FFF_0000) begin fails++; $display("FAIL add_alu_a: got %h want 7fff0000", alu_a); end
      tests++; if (alu_b !== 32'h7FFF_0000) begin fails++; $display("FAIL add_alu_b: got %h want 7fff0000", alu_b); end
      tests++; if ({cmd_ready, done} !== 2'b00) begin fails++; $display("FAIL add_exec_ctl: got %b want 00", {cmd_ready, done}); end
      step();
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL add_done: got %b want 1", done); end
      tests++; if (result !== 32'hFFFE_0000) begin fails++; $display("FAIL add_result: got %h want fffe0000", result); end
      tests++; if ({of_q, zf_q} !== 2'b10) begin fails++; $display("FAIL add_flags: of/zf got %b want 10", {of_q, zf_q}); end
      tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL add_r3_before_wb: got %h want 0", dbg_data); end
      step();
      tests++; if ({cmd_ready, done} !== 2'b10) begin fails++; $display("FAIL add_idle_ctl: got %b want 10", {cmd_ready, done}); end
      tests++; if (dbg_data !== 32'hFFFE_0000) begin fails++; $display("FAIL add_r3: got %h want fffe0000", dbg_data); end
   endtask

   task automatic test_back_to_back();
      issue(3'b101, 5'd1, 5'd1, 5'd4, 1'b1);
      cmd_op = 3'b010; cmd_rs1 = 5'd4; cmd_rs2 = 5'd2; cmd_rd = 5'd5;
      step();
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL b2b_done1: got %b want 1", done); end
      tests++; if ({result, zf_q, of_q} !== {32'h0, 2'b10}) begin fails++; $display("FAIL b2b_sub: result/zf/of got %h %b %b want 0 1 0", result, zf_q, of_q); end
      step();
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle: got %b want 1", cmd_ready); end
      tests++; if (alu_op !== 3'b101) begin fails++; $display("FAIL b2b_op_hold: got %b want 101", alu_op); end
      step();
      cmd_valid = 1'b0;
      tests++; if ({cmd_ready, alu_op} !== {1'b0, 3'b010}) begin fails++; $display("FAIL b2b_accept2: ready/op got %b %b want 0 010", cmd_ready, alu_op); end
      tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL b2b_raw: alu_a got %h want 0", alu_a); end
      step();
      dbg_addr = 5'd5;
      tests++; if (result !== 32'h7FFF_0000) begin fails++; $display("FAIL b2b_xor: got %h want 7fff0000", result); end
      step();
      tests++; if (dbg_data !== 32'h7FFF_0000) begin fails++; $display("FAIL b2b_r5: got %h want 7fff0000", dbg_data); end
   endtask

   task automatic test_logic_rd0();
      do_ld(5'd0, 32'hDEAD_BEEF);
      of_mode = 2'd1;
      issue(3'b000, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL and_done: got %b want 1", done); end
      tests++; if ({result, of_q, zf_q} !== {32'h7FFF_0000, 2'b00}) begin fails++; $display("FAIL and_result: result/of/zf got %h %b %b want 7fff0000 0 0", result, of_q, zf_q); end
      step();
      dbg_addr = 5'd0;
      #1;
      tests++; if (dbg_data !== 32'h0) begin fails++; $display("FAIL r0_zero: got %h want 0", dbg_data); end
      of_mode = 2'd2;
      issue(3'b010, 5'd1, 5'd2, 5'd0, 1'b0);
      step();
      tests++; if ({result, zf_q, of_q} !== {32'h0, 2'b10}) begin fails++; $display("FAIL xor_ofx: result/zf/of got %h %b %b want 0 1 0", result, zf_q, of_q); end
      step();
      of_mode = 2'd0;
   endtask

   task automatic test_shift();
      do_ld(5'd6, 32'h0000_0001);
      do_ld(5'd7, 32'h0000_FFFF);
      issue(3'b111, 5'd6, 5'd7, 5'd8, 1'b0);
      ld_en = 1'b1; ld_addr = 5'd8; ld_data = 32'h1234_5678;
      step();
      tests++; if (result !== 32'h0001_FFFE) begin fails++; $display("FAIL sll_result: got %h want 0001fffe", result); end
      step();
      ld_en = 1'b0;
      dbg_addr = 5'd8;
      #1;
      tests++; if (dbg_data !== 32'h0001_FFFE) begin fails++; $display("FAIL sll_r8: got %h want 0001fffe", dbg_data); end
   endtask

   task automatic test_ld_no_bypass();
      ld_en = 1'b1; ld_addr = 5'd10; ld_data = 32'hAAAA_5555;
      issue(3'b001, 5'd10, 5'd0, 5'd11, 1'b0);
      ld_en = 1'b0;
      dbg_addr = 5'd10;
      #1;
      tests++; if (alu_a !== 32'h0) begin fails++; $display("FAIL nobypass_alu_a: got %h want 0", alu_a); end
      tests++; if (dbg_data !== 32'hAAAA_5555) begin fails++; $display("FAIL nobypass_r10: got %h want aaaa5555", dbg_data); end
      step(); step();
   endtask

   task automatic test_reset_exec();
      int bad;
      issue(3'b100, 5'd1, 5'd2, 5'd9, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      tests++; if ({cmd_ready, done, alu_op} !== {2'b10, 3'b000}) begin fails++; $display("FAIL rstx_async: ready/done/op got %b %b %b want 1 0 000", cmd_ready, done, alu_op); end
      step();
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rstx_no_done: got %b want 0", done); end
      rst_n = 1'b1;
      step();
      tests++; if ({cmd_ready, done, result} !== {2'b10, 32'h0}) begin fails++; $display("FAIL rstx_idle: ready/done/result got %b %b %h want 1 0 0", cmd_ready, done, result); end
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         dbg_addr = i[ADDR_W-1:0];
         #1;
         if (dbg_data !== 32'h0) bad++;
      end
      tests++; if (bad !== 0) begin fails++; $display("FAIL rstx_regfile: %0d nonzero registers, want 0", bad); end
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0; of_mode = 2'd0;
      test_reset();
      test_add_overflow();
      test_back_to_back();
      test_logic_rd0();
      test_shift();
      test_ld_no_bypass();
      test_reset_exec();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
